pipe_ctrl: RTL and testbench

Pipeline control unit for the six-stage RISC-V core. It merges per-stage stall requests into the shared `stall[5:0]` vector and sequences trap and `mret` redirects into a single-cycle `flush` plus `new_pc`. Before flushing, it drains any outstanding data-bus transaction. It also runs a stall watchdog. All stage registers, including MEM/WB, and the PC register consume its outputs.

---
 rtl/pipe_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// ---------
// Pipeline control unit for the six-stage RISC-V core.  Merges the per-stage
// stall requests into one hold vector and sequences trap / mret redirects into
// a single-cycle flush plus redirect target.  Any outstanding data-bus
// transaction is drained before the flush.  A stall watchdog flags
// pathological stall runs.
//
// Ports
//   clk          core clock
//   rst          synchronous, active-high reset
//   stallreq_if  fetch bus wait
//   stallreq_id  load-use hazard
//   stallreq_ex  multicycle ALU busy
//   stallreq_mem data bus wait
//   mem_busy     data-bus transaction outstanding
//   excp_req     trap request from MEM (wins over mret_req)
//   mret_req     mret retiring in MEM
//   trap_vec     trap target
//   mepc         mret return address
//   stall[5:0]   hold per register: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
//   flush        kill all stage registers (one cycle per redirect)
//   new_pc       redirect target while flush=1, otherwise 0
//   wdt_timeout  sticky watchdog flag, cleared only by rst

module pipe_ctrl #(
  parameter int unsigned WDT_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        mem_busy,
  input  logic        excp_req,
  input  logic        mret_req,
  input  logic [31:0] trap_vec,
  input  logic [31:0] mepc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        wdt_timeout
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    POST  = 2'd2
  } state_t;

  localparam logic [5:0]  STALL_MEM = 6'b011111;
  localparam logic [5:0]  STALL_EX  = 6'b001111;
  localparam logic [5:0]  STALL_ID  = 6'b000111;
  localparam logic [5:0]  STALL_IF  = 6'b000011;
  localparam logic [31:0] WDT_TRIP  = 32'(WDT_LIMIT - 1);
  localparam logic [31:0] WDT_MAX   = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic [31:0] pendPc_q, pendPc_d;
  logic [31:0] wdtCnt_q;
  logic        wdtTimeout_q;

  logic [5:0]  stallEnc;
  logic        redir;
  logic [31:0] redirTarget;

  // Priority-encode the stage stall requests.  A stalled stage must also hold
  // every stage upstream of it, so the deepest requester sets the mask.
  always_comb begin
    stallEnc = 6'b000000;
    if (stallreq_mem) begin
      stallEnc = STALL_MEM;
    end else if (stallreq_ex) begin
      stallEnc = STALL_EX;
    end else if (stallreq_id) begin
      stallEnc = STALL_ID;
    end else if (stallreq_if) begin
      stallEnc = STALL_IF;
    end
  end

  // A trap outranks a simultaneous mret, so the mret is simply dropped.
  assign redir       = excp_req | mret_req;
  assign redirTarget = excp_req ? trap_vec : mepc;

  // Output and next-state decode.  Outputs are combinational so the stage
  // registers see the flush in the very cycle the redirect is accepted.
  // While draining, the whole pipe up to MEM is held and the redirect
  // inputs are ignored; the target was captured on entry.  POST masks the
  // redirect inputs because they stem from instructions being flushed.
  always_comb begin
    stall    = stallEnc;
    flush    = 1'b0;
    new_pc   = 32'h0;
    state_d  = state_q;
    pendPc_d = pendPc_q;
    case (state_q)
      RUN: begin
        if (redir && !mem_busy) begin
          stall   = 6'b000000;
          flush   = 1'b1;
          new_pc  = redirTarget;
          state_d = POST;
        end else if (redir) begin
          stall    = STALL_MEM;
          pendPc_d = redirTarget;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (!mem_busy) begin
          stall   = 6'b000000;
          flush   = 1'b1;
          new_pc  = pendPc_q;
          state_d = POST;
        end else begin
          stall = STALL_MEM;
        end
      end
      POST: begin
        state_d = RUN;
      end
      default: begin
        stall   = 6'b000000;
        state_d = RUN;
      end
    endcase
  end

  // State, latched target and watchdog.  The watchdog counts consecutive
  // stalled cycles, restarts whenever the pipe moves or is flushed, saturates
  // instead of wrapping, and trips when the count reaches WDT_LIMIT-1 in a
  // cycle that is still stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pendPc_q     <= 32'h0;
      wdtCnt_q     <= 32'h0;
      wdtTimeout_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pendPc_q <= pendPc_d;
      if ((stall == 6'b000000) || flush) begin
        wdtCnt_q <= 32'h0;
      end else begin
        if (wdtCnt_q == WDT_TRIP) begin
          wdtTimeout_q <= 1'b1;
        end
        if (wdtCnt_q != WDT_MAX) begin
          wdtCnt_q <= wdtCnt_q + 32'h1;
        end
      end
    end
  end

  assign wdt_timeout = wdtTimeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// ------------
// Directed bench for pipe_ctrl with a short watchdog (WDT_LIMIT=8).  Inputs
// change 1 time unit after a rising edge; outputs are compared just after,
// well away from the next edge.

module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        mem_busy;
  logic        excp_req;
  logic        mret_req;
  logic [31:0] trap_vec;
  logic [31:0] mepc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        wdt_timeout;

  int totalChecks = 0;
  int badChecks   = 0;

  pipe_ctrl #(.WDT_LIMIT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .mem_busy     (mem_busy),
    .excp_req     (excp_req),
    .mret_req     (mret_req),
    .trap_vec     (trap_vec),
    .mepc         (mepc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .wdt_timeout  (wdt_timeout)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive the stall request and redirect inputs in one go.
  task automatic applyStimulus(input logic sIf, input logic sId, input logic sEx,
                               input logic sMem, input logic busy,
                               input logic excp, input logic mret,
                               input logic [31:0] tvec, input logic [31:0] epc);
    stallreq_if  = sIf;
    stallreq_id  = sId;
    stallreq_ex  = sEx;
    stallreq_mem = sMem;
    mem_busy     = busy;
    excp_req     = excp;
    mret_req     = mret;
    trap_vec     = tvec;
    mepc         = epc;
    #1;
  endtask

  // Advance one clock, landing 1 unit after the rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("rst_stall", 32'(stall), 32'h0);
    checkOutput("rst_flush", 32'(flush), 32'h0);
    checkOutput("rst_newpc", new_pc, 32'h0);
    checkOutput("rst_wdt", 32'(wdt_timeout), 32'h0);
    rst = 1'b0;

    // Stall priority, purely combinational (no edges, watchdog untouched).
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("prio_id_mem", 32'(stall), 32'h1F);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("prio_id", 32'(stall), 32'h07);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("prio_if", 32'(stall), 32'h03);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("prio_ex", 32'(stall), 32'h0F);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("prio_none", 32'(stall), 32'h00);

    // Trap with idle bus and a concurrent EX stall that must be overridden.
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 32'h8000_0100, 32'h0);
    checkOutput("trap_flush", 32'(flush), 32'h1);
    checkOutput("trap_newpc", new_pc, 32'h8000_0100);
    checkOutput("trap_stall", 32'(stall), 32'h0);
    nextCycle();
    checkOutput("post_flush", 32'(flush), 32'h0);
    checkOutput("post_newpc", new_pc, 32'h0);
    checkOutput("post_stall", 32'(stall), 32'h0F);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("run_again_flush", 32'(flush), 32'h0);

    // mret with the bus busy for the request cycle plus three drain cycles.
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0000_1234);
    checkOutput("drain_req_stall", 32'(stall), 32'h1F);
    checkOutput("drain_req_flush", 32'(flush), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 32'h0BAD_0000, 32'hDEAD_0000 + 32'(i));
      checkOutput($sformatf("drain%0d_stall", i), 32'(stall), 32'h1F);
      checkOutput($sformatf("drain%0d_flush", i), 32'(flush), 32'h0);
    end
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'hDEAD_BEEF);
    checkOutput("drain_done_flush", 32'(flush), 32'h1);
    checkOutput("drain_done_newpc", new_pc, 32'h0000_1234);
    checkOutput("drain_done_stall", 32'(stall), 32'h0);
    nextCycle();
    checkOutput("drain_post_flush", 32'(flush), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    nextCycle();

    // Simultaneous trap and mret: the trap wins, one flush only.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h0000_0100, 32'h0000_0200);
    checkOutput("both_flush", 32'(flush), 32'h1);
    checkOutput("both_newpc", new_pc, 32'h0000_0100);
    nextCycle();
    checkOutput("both_post_flush", 32'(flush), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("both_gone_flush", 32'(flush), 32'h0);

    // Watchdog: seven stalled cycles are tolerated, the eighth trips it.
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++) nextCycle();
    checkOutput("wdt_7", 32'(wdt_timeout), 32'h0);
    nextCycle();
    checkOutput("wdt_8", 32'(wdt_timeout), 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("wdt_sticky", 32'(wdt_timeout), 32'h1);
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    checkOutput("wdt_rst", 32'(wdt_timeout), 32'h0);

    // Reset in the second drain cycle discards the pending redirect.
    applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h0000_4444);
    checkOutput("rd_req_stall", 32'(stall), 32'h1F);
    nextCycle();
    checkOutput("rd_d1_flush", 32'(flush), 32'h0);
    nextCycle();
    rst = 1'b1;
    checkOutput("rd_d2_flush", 32'(flush), 32'h0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("rd_after_stall", 32'(stall), 32'h0);
    checkOutput("rd_after_flush", 32'(flush), 32'h0);
    checkOutput("rd_after_newpc", new_pc, 32'h0);
    nextCycle();
    checkOutput("rd_later_flush", 32'(flush), 32'h0);
    checkOutput("rd_later_newpc", new_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
